muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core.
//  Operands come from the register file read ports (rd1 -> a, rd2 -> b).
//  mfhi/mflo results go back through the writeback mux onto the register file wd port.
//  Asserts busy so the core stalls the PC while a MULT/DIV is in flight.
// PARAMETERS
//  WIDTH  32  operand/HI/LO width; iteration count = WIDTH
// PORTS
//  clk     in   1      single clock, rising edge
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      launch op (decoded MULT/MULTU/DIV/DIVU)
//  op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a       in   WIDTH  rs operand (rd1)
//  b       in   WIDTH  rt operand (rd2)
//  mthi    in   1      write a into HI
//  mtlo    in   1      write a into LO
//  busy    out  1      op in flight; core must stall
//  done    out  1      one-cycle pulse when HI/LO updated by an op
//  hi      out  WIDTH  HI register (to writeback mux)
//  lo      out  WIDTH  LO register (to writeback mux)
// BEHAVIOUR
//  - Clocking/reset: one clock; reset is asynchronous and active-low.
//    rst_n=0 -> state IDLE, hi=lo=0, busy=0, done=0, counter=0.
//  - FSM: IDLE -> RUN -> FIX -> DONE -> IDLE.
//    - IDLE: start=1 latches op, |a|, |b| and result signs; goes to RUN, busy=1 from next cycle.
//    - RUN: WIDTH cycles.
//      - Multiply: shift-add on a 2*WIDTH accumulator.
//      - Divide: restoring divide (trial subtract, shift in quotient bit).
//      - 6-bit counter counts WIDTH-1 down to 0; leaves to FIX on 0.
//    - FIX: apply sign correction.
//      - MULT: negate 64-bit product if signs differ.
//      - DIV: negate quotient if signs differ; remainder takes the sign of the dividend.
//    - DONE: write hi/lo (mult: hi=prod[63:32], lo=prod[31:0]; div: lo=quot, hi=rem); done=1 this cycle; busy=0 next.
//  - Latency: start at cycle 0 -> hi/lo valid and done=1 at cycle WIDTH+2 (34). busy high cycles 1..34.
//  - Unsigned ops (MULTU/DIVU) skip abs/negate; operands are zero-extended.
//  - Divide by zero (b=0): no trap; still full latency. Result lo=32'hFFFFFFFF, hi=a.
//  - Signed overflow (DIV a=32'h80000000, b=32'hFFFFFFFF): lo=32'h80000000, hi=0.
//  - start while busy: ignored; the in-flight op completes unchanged.
//  - mthi/mtlo:
//    - Honoured only when not busy; dropped while busy.
//    - mthi/mtlo in the same cycle as start (IDLE): the write happens, and the op result later overwrites it.
//    - mthi and mtlo together: both written with a.
//  - hi/lo are stable between writes. Reads are combinational from the registers; there is no bypass of an in-flight op.
//  - rst_n asserted mid-op: op aborted immediately; hi/lo cleared; no done pulse.
// STRUCTURE
//  - muldiv_pkg: op encodings (OP_MULT..OP_DIVU), FSM state localparams (S_IDLE, S_RUN, S_FIX, S_DONE), WIDTH default.
//  - One sub-module, muldiv_negate: WIDTH-generic two's-complement conditional negate.
//    Used for operand abs, product/quotient fix and remainder fix.
//  - Everything else in one always block (FSM + datapath) plus output assigns.
// TESTING
//  1. MULT a=-3 (FFFFFFFD), b=7 -> at cycle 34 done=1, hi=FFFFFFFF, lo=FFFFFFEB; busy cycles 1..34.
//  2. MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
//  3. DIV a=-7, b=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1).
//     DIVU a=7, b=2 -> lo=3, hi=1.
//  4. Corner divides:
//     - DIV a=12345678, b=0 -> lo=FFFFFFFF, hi=12345678.
//     - DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
//  5. Start MULT 2*3, pulse start again with op=DIV at cycle 5, and mthi a=AAAA at cycle 10
//     -> both ignored; hi=0, lo=6 at cycle 34. Then mtlo a=55 in IDLE -> lo=55 next cycle.
//  6. Start DIVU, drop rst_n at cycle 12 -> busy=0, hi=lo=0 immediately, no done.
//     Release rst_n and start MULT 4*5 -> lo=20 after 34 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit.
//   DEF_WIDTH : default operand / HI / LO width
//   op_e      : operation encodings on the op port
//   state_e   : sequencer states
package muldiv_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate.
//   x   : value in
//   neg : 1 -> y = -x, 0 -> y = x
//   y   : value out
module muldiv_negate #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? ((~x) + W'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   start : launch MULT/MULTU/DIV/DIVU (ignored while busy)
//   op    : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b  : rs / rt operands
//   mthi  : write a into HI (only when not busy)
//   mtlo  : write a into LO (only when not busy)
//   busy  : op in flight, core stalls
//   done  : one-cycle pulse when HI/LO were updated by an op
//   hi,lo : HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_e             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;      // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   dvsr;     // |multiplicand| or |divisor|
  logic               is_div_r;
  logic               sign_q;   // product / quotient needs negation
  logic               sign_r;   // remainder takes dividend sign
  logic               div0;
  logic [WIDTH-1:0]   hi_r, lo_r;

  // operand decode
  op_e        op_c;
  logic       is_div, is_sgn, sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign op_c   = op_e'(op);
  assign is_div = (op_c == OP_DIV) || (op_c == OP_DIVU);
  assign is_sgn = (op_c == OP_MULT) || (op_c == OP_DIV);
  assign sa     = is_sgn & a[WIDTH-1];
  assign sb     = is_sgn & b[WIDTH-1];

  muldiv_negate #(.W(WIDTH)) u_abs_a (.x(a), .neg(sa), .y(abs_a));
  muldiv_negate #(.W(WIDTH)) u_abs_b (.x(b), .neg(sb), .y(abs_b));

  // shift-add multiply step: add multiplicand into upper half when lsb set, shift right
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nx;

  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvsr} : '0);
  assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

  // restoring divide step: shift next dividend bit into remainder, trial subtract
  logic [WIDTH:0]     div_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_nx;

  assign div_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign div_ge   = div_sh >= {1'b0, dvsr};
  assign div_diff = div_sh[WIDTH-1:0] - dvsr;
  assign div_nx   = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

  // sign correction; a zero divisor leaves the all-ones quotient untouched
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  muldiv_negate #(.W(2*WIDTH)) u_fix_p (.x(acc),                   .neg(sign_q),         .y(prod_fix));
  muldiv_negate #(.W(WIDTH))   u_fix_q (.x(acc[WIDTH-1:0]),        .neg(sign_q & ~div0), .y(quot_fix));
  muldiv_negate #(.W(WIDTH))   u_fix_r (.x(acc[2*WIDTH-1:WIDTH]),  .neg(sign_r),         .y(rem_fix));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (cnt == '0) state_nx = S_FIX;
      S_FIX:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      dvsr     <= '0;
      is_div_r <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div0     <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mthi) hi_r <= a;
          if (mtlo) lo_r <= a;
          if (start) begin
            cnt      <= CW'(WIDTH - 1);
            acc      <= {{WIDTH{1'b0}}, abs_a};
            dvsr     <= abs_b;
            is_div_r <= is_div;
            sign_q   <= sa ^ sb;
            sign_r   <= sa;
            div0     <= (b == '0);
          end
        end
        S_RUN: begin
          cnt <= cnt - CW'(1);
          acc <= is_div_r ? div_nx : mul_nx;
        end
        // results land on the FIX->DONE edge so they are visible while done is high
        S_FIX: begin
          if (is_div_r) begin
            hi_r <= rem_fix;
            lo_r <= quot_fix;
          end else begin
            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule
